// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin arbiter that gives one of four drawing
// engines (map, pacman, ghost A, ghost B) exclusive use of the VGA adapter.
// Each grant is bounded by a hold counter. One RELEASE cycle separates a
// grant from the next arbitration.
//
// Handshake: a requester raises req[i] and keeps it high until it is finished.
// grant[i] is registered, one-hot, and acts as the requester's enable. While it
// holds the grant, the requester's plot/x/y/color go through to the adapter in
// the same cycle. The requester ends its turn in one of two ways: it pulses
// done[i], or it drops req[i]. The pixel presented alongside done[i] is still
// plotted. If the requester does neither, the hold counter revokes the grant
// after TIMEOUT cycles and timeout_err flags it.
module vga_plot_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd40000
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  done,
  input  logic [3:0]  plot_in,
  input  logic [31:0] x_in,
  input  logic [27:0] y_in,
  input  logic [11:0] color_in,
  output logic [3:0]  grant,
  output logic        vga_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_color,
  output logic        busy,
  output logic        timeout_err,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_grant;
  logic [3:0]  w_grant_nxt;
  // r_last is both the round-robin pointer and the index of the current holder
  logic [1:0]  r_last;
  logic [1:0]  w_last_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        r_timeout_err;
  logic        w_timeout_err_nxt;

  logic [1:0]  w_winner;
  logic        w_found;
  logic [1:0]  w_cand;
  logic        w_g_done;
  logic        w_g_req;
  logic        w_at_limit;
  logic        w_exit;

  // Round-robin search: first set req bit starting just after the last winner
  always_comb begin
    w_winner = r_last;
    w_found  = 1'b0;
    w_cand   = r_last;
    for (int k = 1; k < 5; k++) begin
      w_cand = r_last + 2'(k);
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Exit conditions of the current holder; only its own done/req matter
  always_comb begin
    w_g_done   = done[r_last];
    w_g_req    = req[r_last];
    w_at_limit = (r_cnt == (TIMEOUT - 16'd1));
    w_exit     = w_g_done | ~w_g_req | w_at_limit;
  end

  // Next-state, next-grant, hold counter and timeout flag
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_last_nxt        = r_last;
    w_cnt_nxt         = r_cnt;
    w_timeout_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = 4'b0000;
        w_cnt_nxt   = 16'd0;
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_grant_nxt = 4'b0001 << w_winner;
          w_last_nxt  = w_winner;
        end
      end
      S_GRANT: begin
        if (w_exit) begin
          w_state_nxt       = S_RELEASE;
          w_grant_nxt       = 4'b0000;
          w_cnt_nxt         = 16'd0;
          // A revocation counts as an error only if the requester still wanted the port
          w_timeout_err_nxt = w_at_limit & ~w_g_done & w_g_req;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
        w_cnt_nxt   = 16'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // State register; reset wins over every transition
  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_grant       <= 4'b0000;
      r_last        <= 2'd3;
      r_cnt         <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_last        <= w_last_nxt;
      r_cnt         <= w_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  // VGA mux: pass the holder's pixel through during GRANT, zeros otherwise
  always_comb begin
    vga_plot  = 1'b0;
    vga_x     = 8'd0;
    vga_y     = 7'd0;
    vga_color = 3'd0;
    if (r_state == S_GRANT) begin
      case (r_last)
        2'd0: begin
          vga_plot  = plot_in[0];
          vga_x     = x_in[7:0];
          vga_y     = y_in[6:0];
          vga_color = color_in[2:0];
        end
        2'd1: begin
          vga_plot  = plot_in[1];
          vga_x     = x_in[15:8];
          vga_y     = y_in[13:7];
          vga_color = color_in[5:3];
        end
        2'd2: begin
          vga_plot  = plot_in[2];
          vga_x     = x_in[23:16];
          vga_y     = y_in[20:14];
          vga_color = color_in[8:6];
        end
        default: begin
          vga_plot  = plot_in[3];
          vga_x     = x_in[31:24];
          vga_y     = y_in[27:21];
          vga_color = color_in[11:9];
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign busy        = (r_state == S_GRANT) || (r_state == S_RELEASE);
  assign timeout_err = r_timeout_err;
  assign o_dbg_state = r_state;

endmodule
